uart_rx: RTL

// Serial receiver for the tic-tac-toe UART link. Consumes the 8N1 stream produced by the TX side
// (idle-high line, start 0, 8 data bits LSB first, stop 1) and recovers bytes.

---
 rtl/uart_rx.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/uart_rx.sv
// 8N1 serial receiver with a one-entry valid/ready holding register.
// Samples mid-bit after a two-flop synchroniser and flags framing errors and overruns.
module uart_rx #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       rx_in,
    output logic [7:0] data_out,
    output logic       data_valid,
    input  logic       data_ready,
    output logic       busy,
    output logic       frame_err,
    output logic       overrun
);

    localparam int HALF = (CLKS_PER_BIT - 1) / 2;
    localparam int CW   = $clog2(CLKS_PER_BIT + 1);

    // Down-counter reload values: the sample edge is the one where the count reaches zero.
    localparam logic [CW-1:0] HALF_LOAD = CW'((HALF > 0) ? HALF - 1 : 0);
    localparam logic [CW-1:0] BIT_LOAD  = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } state_t;

    state_t          state;
    logic            sync_meta;
    logic            rx_s;
    logic [CW-1:0]   bit_cnt;
    logic [2:0]      bit_idx;
    logic [7:0]      shift;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_meta  <= 1'b1;
            rx_s       <= 1'b1;
            state      <= IDLE;
            bit_cnt    <= '0;
            bit_idx    <= '0;
            shift      <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
            busy       <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            sync_meta <= rx_in;
            rx_s      <= sync_meta;
            frame_err <= 1'b0;
            overrun   <= 1'b0;

            // A byte loaded in STOP below overrides this clear on the same edge.
            if (data_valid && data_ready) begin
                data_valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        busy    <= 1'b1;
                        bit_idx <= '0;
                        if (HALF == 0) begin
                            state   <= DATA;
                            bit_cnt <= BIT_LOAD;
                        end else begin
                            state   <= START;
                            bit_cnt <= HALF_LOAD;
                        end
                    end
                end

                START: begin
                    if (bit_cnt == '0) begin
                        if (rx_s) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            state   <= DATA;
                            bit_cnt <= BIT_LOAD;
                        end
                    end else begin
                        bit_cnt <= bit_cnt - 1'b1;
                    end
                end

                DATA: begin
                    if (bit_cnt == '0) begin
                        shift   <= {rx_s, shift[7:1]};
                        bit_cnt <= BIT_LOAD;
                        bit_idx <= bit_idx + 1'b1;
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                        end
                    end else begin
                        bit_cnt <= bit_cnt - 1'b1;
                    end
                end

                STOP: begin
                    if (bit_cnt == '0) begin
                        if (rx_s) begin
                            if (!data_valid || data_ready) begin
                                data_out   <= shift;
                                data_valid <= 1'b1;
                            end else begin
                                overrun <= 1'b1;
                            end
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= WAIT_HIGH;
                        end
                    end else begin
                        bit_cnt <= bit_cnt - 1'b1;
                    end
                end

                WAIT_HIGH: begin
                    if (rx_s) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
